pipeline_stall_controller: RTL
==============================

# pipeline_stall_controller

Generates per-stage enable and flush controls for the processor pipeline registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Its enable outputs drive the Enable inputs of those registers and its flush outputs drive their synchronous Reset inputs. It resolves load-use hazards, multi-cycle execute operations, taken branches and external memory holds. It sits directly upstream of every pipeline register bank, including the one-bit status registers.

## Interface
- COUNT_W, 5, width of the multi-cycle length input and the internal down-counter
- CLK  in  1  pipeline clock
- Reset  in  1  asynchronous, active-high; one clock domain only
- ExtHold  in  1  memory not ready; freeze the whole pipeline
- BranchTaken  in  1  taken branch resolved in EX
- MultiStart  in  1  EX holds a multi-cycle op; valid one cycle
- MultiCycles  in  COUNT_W  stall cycles N required by that op
- LoadUseHazard  in  1  ID consumes the result of a load currently in EX
- PcEnable, IfIdEnable, IdExEnable, ExMemEnable, MemWbEnable  out  1 each  register enables
- IfIdFlush, IdExFlush, ExMemFlush  out  1 each  bubble insertion (register sync reset)
- Busy  out  1  high while in MULTI

## Operation
- States: RUN, MULTI. Internal counter Count is COUNT_W bits wide.
- Outputs are combinational from state and inputs (Mealy), so stalls take effect in the same cycle.
- Default in RUN with no event: all enables 1, all flushes 0.
- Event priority in RUN, highest first: ExtHold, BranchTaken, MultiStart, LoadUseHazard.
- ExtHold: all enables 0, all flushes 0, state and Count frozen. Applies in every state.
- BranchTaken: all enables 1, IfIdFlush=1, IdExFlush=1. State stays RUN. A simultaneous MultiStart or LoadUseHazard is discarded.
- MultiStart with N=0: ignored; normal RUN behaviour applies, including LoadUseHazard.
- MultiStart with N≥1: the current cycle is stall cycle 1.
  - Stall outputs: PcEnable, IfIdEnable and IdExEnable are 0; ExMemEnable=1 with ExMemFlush=1; MemWbEnable=1.
  - N=1: remain in RUN.
  - N≥2: load Count=N-1 and go to MULTI.
- MULTI, when not held:
  - Drive the stall outputs.
  - If Count==1, go to RUN. Otherwise decrement Count.
  - BranchTaken, MultiStart and LoadUseHazard are ignored.
- Total stall cycles for N≥1 are exactly N non-held cycles. The EX op advances on the following cycle.
- LoadUseHazard: PcEnable=0, IfIdEnable=0, IdExFlush=1, all other enables 1. State stays RUN. The hazard self-clears once the load moves to MEM.
- Busy = (state==MULTI).

## Timing
- Reset asserted (asynchronous): state=RUN and Count=0 immediately. While Reset is high, all enables are 0, all flushes are 1, and Busy=0.
- Reset asserted mid-MULTI aborts the operation. There is no residual stall after Reset is released.
- First cycle after Reset is released: default RUN outputs.
- Zero-cycle latency from any input to any output. State and Count update on the CLK rising edge.
- ExtHold during MULTI extends the stall in wall-clock cycles without consuming Count.
- MultiCycles is sampled only in the MultiStart cycle; later changes have no effect.
- N = 2^COUNT_W − 1 is the maximum; there is no wrap-around.

## Configuration
- STALL_COUNTER_EN defined:
  - Adds output port StallCycles (out, 16 bits).
  - StallCycles counts every cycle with PcEnable=0 and Reset low; the cause may be hazard, multi-cycle or ExtHold.
  - The counter saturates at 0xFFFF and is cleared to 0 by Reset.
- STALL_COUNTER_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - the state encoding (RUN=1'b0, MULTI=1'b1);
  - the COUNT_W default;
  - the StallCycles width (16) and saturation constant.
- One sub-module: stall_down_counter. It provides load, decrement and hold-enable, an is-one flag, and async reset to 0.
- The FSM and output decode stay in the top module.

## Test plan
- Reset asserted mid-MULTI with Count=3 → next cycle state=RUN, Busy=0. While Reset is high, all enables are 0 and flushes 1. After release, default outputs.
- LoadUseHazard=1 for one cycle in RUN → that cycle PcEnable=0, IfIdEnable=0, IdExFlush=1, ExMemEnable=1. The next cycle returns to defaults.
- MultiStart with MultiCycles=4 → 4 consecutive cycles with IdExEnable=0 and ExMemFlush=1, Busy high on cycles 2–4, then RUN. With ExtHold=1 for 2 cycles in the middle, the stall spans 6 cycles, all flushes are 0 during the hold, and Count is unchanged.
- BranchTaken and LoadUseHazard in the same cycle → IfIdFlush=1, IdExFlush=1, PcEnable=1, IfIdEnable=1. BranchTaken and MultiStart (N=3) together → no entry into MULTI.
- MultiStart with N=0 → no stall. With N=1 → exactly one stall cycle and Busy stays 0.
- STALL_COUNTER_EN: 3 hazard cycles plus a 4-cycle multi op plus 2 ExtHold cycles → StallCycles=9. Forced to 0xFFFF, it stays at 0xFFFF on a further stall.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM state encoding,
// default down-counter width and the stall-statistics counter constants.
package pipeline_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_MULTI = 1'b1
    } state_e;

    localparam int COUNT_W_DEF = 5;

    localparam int                     STALL_CNT_W   = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/stall_down_counter.sv
// Loadable down-counter that tracks the remaining multi-cycle stall length.
// en_i low freezes the counter completely (external hold); async reset to 0.
module stall_down_counter #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         is_one_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins over decrement; never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            if (load_i) begin
                count_d = load_val_i;
            end else if (dec_i && (count_q != '0)) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign is_one_o = (count_q == W'(1));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Per-stage enable/flush generation for the PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB registers. Outputs are Mealy so every stall acts in the same cycle.
// Optional feature: define STALL_COUNTER_EN to add the saturating 16-bit
// StallCycles statistics output.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               ExtHold,
    input  logic               BranchTaken,
    input  logic               MultiStart,
    input  logic [COUNT_W-1:0] MultiCycles,
    input  logic               LoadUseHazard,
    output logic               PcEnable,
    output logic               IfIdEnable,
    output logic               IdExEnable,
    output logic               ExMemEnable,
    output logic               MemWbEnable,
    output logic               IfIdFlush,
    output logic               IdExFlush,
    output logic               ExMemFlush,
    output logic               Busy
`ifdef STALL_COUNTER_EN
    ,
    output logic [STALL_CNT_W-1:0] StallCycles
`endif
);

    state_e             state_q;
    state_e             state_d;
    logic               cnt_load;
    logic               cnt_dec;
    logic [COUNT_W-1:0] cnt_val;
    logic               cnt_is_one;

    stall_down_counter #(
        .W(COUNT_W)
    ) u_counter (
        .clk_i      (CLK),
        .rst_i      (Reset),
        .en_i       (~ExtHold),
        .load_i     (cnt_load),
        .load_val_i (COUNT_W'(MultiCycles - 1'b1)),
        .dec_i      (cnt_dec),
        .count_o    (cnt_val),
        .is_one_o   (cnt_is_one)
    );

    // Next-state and output decode; reset forces enables low and flushes high.
    always_comb begin
        state_d     = state_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        PcEnable    = 1'b1;
        IfIdEnable  = 1'b1;
        IdExEnable  = 1'b1;
        ExMemEnable = 1'b1;
        MemWbEnable = 1'b1;
        IfIdFlush   = 1'b0;
        IdExFlush   = 1'b0;
        ExMemFlush  = 1'b0;

        if (ExtHold) begin
            // Whole pipeline frozen, state and count untouched.
            PcEnable    = 1'b0;
            IfIdEnable  = 1'b0;
            IdExEnable  = 1'b0;
            ExMemEnable = 1'b0;
            MemWbEnable = 1'b0;
        end else if (state_q == ST_MULTI) begin
            PcEnable   = 1'b0;
            IfIdEnable = 1'b0;
            IdExEnable = 1'b0;
            ExMemFlush = 1'b1;
            if (cnt_is_one) begin
                state_d = ST_RUN;
            end else begin
                cnt_dec = 1'b1;
            end
        end else if (BranchTaken) begin
            IfIdFlush = 1'b1;
            IdExFlush = 1'b1;
        end else if (MultiStart && (MultiCycles != '0)) begin
            // This cycle is stall cycle 1; MULTI covers the remaining N-1.
            PcEnable   = 1'b0;
            IfIdEnable = 1'b0;
            IdExEnable = 1'b0;
            ExMemFlush = 1'b1;
            if (MultiCycles != COUNT_W'(1)) begin
                cnt_load = 1'b1;
                state_d  = ST_MULTI;
            end
        end else if (LoadUseHazard) begin
            PcEnable   = 1'b0;
            IfIdEnable = 1'b0;
            IdExFlush  = 1'b1;
        end

        if (Reset) begin
            PcEnable    = 1'b0;
            IfIdEnable  = 1'b0;
            IdExEnable  = 1'b0;
            ExMemEnable = 1'b0;
            MemWbEnable = 1'b0;
            IfIdFlush   = 1'b1;
            IdExFlush   = 1'b1;
            ExMemFlush  = 1'b1;
        end
    end

    // State register; reset aborts any multi-cycle stall in progress.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign Busy = (state_q == ST_MULTI);

`ifdef STALL_COUNTER_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    // Count cycles with the PC frozen, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PcEnable && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall statistics register, cleared by reset.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCycles = stall_cnt_q;
`else
    // The down-counter value is only needed for its is-one flag here.
    logic unused_cnt;
    assign unused_cnt = ^cnt_val;
`endif

endmodule
